// File: rtl/key_pkg.sv
// key_pkg -- shared definitions for the key debounce controller.
//   key_state_t : FSM state encoding (IDLE, DLY_PRESS, WAIT_REL, DLY_REL)
//   DLY_W/HOLD_W: widths of the debounce delay counter and long-press hold counter
//   T10MS_DEF   : default debounce terminal count (10 ms at 50 MHz)
//   T1S_DEF     : default long-press terminal count (1 s at 50 MHz)
`timescale 1ns/1ps
package key_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        DLY_PRESS = 2'd1,
        WAIT_REL  = 2'd2,
        DLY_REL   = 2'd3
    } key_state_t;

    localparam int DLY_W  = 20;
    localparam int HOLD_W = 26;

    localparam logic [DLY_W-1:0]  T10MS_DEF = 20'd499_999;
    localparam logic [HOLD_W-1:0] T1S_DEF   = 26'd49_999_999;

endpackage

// File: rtl/key_delay_timer.sv
// key_delay_timer -- saturating up-counter with synchronous clear.
//   CLK  : clock, rising edge
//   RSTn : asynchronous active-low reset (count -> 0)
//   clr  : synchronous clear, wins over en
//   en   : count enable; counting stops at TERM so the counter never wraps
//   done : high while the count equals TERM
`timescale 1ns/1ps
module key_delay_timer #(
    parameter int               WIDTH = 20,
    parameter logic [WIDTH-1:0] TERM  = '1
) (
    input  logic CLK,
    input  logic RSTn,
    input  logic clr,
    input  logic en,
    output logic done
);

    localparam logic [WIDTH-1:0] ONE = 1;

    logic [WIDTH-1:0] cnt;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != TERM)) begin
            cnt <= cnt + ONE;
        end
    end

    assign done = (cnt == TERM);

endmodule

// File: rtl/key_debounce_ctrl.sv
// key_debounce_ctrl -- debounces a key using upstream edge pulses and the raw level.
// Optional feature: define KEY_LONG_PRESS_EN to enable the long-press pulse.
//   CLK         : system clock (50 MHz), rising edge
//   RSTn        : asynchronous active-low reset
//   Pin_In      : raw key level, low = pressed
//   H2L_Sig     : one-cycle falling-edge pulse
//   L2H_Sig     : one-cycle rising-edge pulse
//   Key_Press   : one-cycle pulse on confirmed press
//   Key_Release : one-cycle pulse on confirmed release
//   Key_Level   : debounced level, 1 = released
//   Key_Long    : one-cycle pulse after a press is held T1S cycles (0 when feature off)
//   dbg_state   : current FSM state, for observation only
//
// Handshake: there is none; edge inputs are single-cycle strobes, acted on only in
// the state that waits for them, and all pulse outputs are registered strobes.
`timescale 1ns/1ps
module key_debounce_ctrl
    import key_pkg::*;
#(
    parameter logic [DLY_W-1:0]  T10MS = T10MS_DEF,
    parameter logic [HOLD_W-1:0] T1S   = T1S_DEF
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       Pin_In,
    input  logic       H2L_Sig,
    input  logic       L2H_Sig,
    output logic       Key_Press,
    output logic       Key_Release,
    output logic       Key_Level,
    output logic       Key_Long,
    output key_state_t dbg_state
);

    key_state_t state, next_state;

    logic dly_clr, dly_en, dly_done;
    logic press_set, rel_set;

    // Delay counter is cleared on every state change, so each debounce window
    // starts from zero regardless of how it was entered.
    key_delay_timer #(
        .WIDTH (DLY_W),
        .TERM  (T10MS)
    ) u_dly_timer (
        .CLK  (CLK),
        .RSTn (RSTn),
        .clr  (dly_clr),
        .en   (dly_en),
        .done (dly_done)
    );

    // State register
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; edge pulses are ignored inside the debounce windows.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      if (H2L_Sig)  next_state = DLY_PRESS;
            DLY_PRESS: if (dly_done) next_state = Pin_In ? IDLE : WAIT_REL;
            WAIT_REL:  if (L2H_Sig)  next_state = DLY_REL;
            DLY_REL:   if (dly_done) next_state = Pin_In ? IDLE : WAIT_REL;
            default:                 next_state = IDLE;
        endcase
    end

    // Output / control decode
    always_comb begin
        press_set = 1'b0;
        rel_set   = 1'b0;
        dly_en    = 1'b0;
        dly_clr   = (next_state != state);
        case (state)
            DLY_PRESS: begin
                dly_en    = 1'b1;
                press_set = dly_done && !Pin_In;
            end
            DLY_REL: begin
                dly_en  = 1'b1;
                rel_set = dly_done && Pin_In;
            end
            default: ;
        endcase
    end

    // Registered pulse and level outputs
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            Key_Press   <= 1'b0;
            Key_Release <= 1'b0;
            Key_Level   <= 1'b1;
        end else begin
            Key_Press   <= press_set;
            Key_Release <= rel_set;
            if (press_set) begin
                Key_Level <= 1'b0;
            end else if (rel_set) begin
                Key_Level <= 1'b1;
            end
        end
    end

`ifdef KEY_LONG_PRESS_EN
    logic hold_done, hold_done_d;

    // Hold counter restarts only on a fresh confirmed press; a bounce back from
    // DLY_REL keeps the accumulated hold time.
    key_delay_timer #(
        .WIDTH (HOLD_W),
        .TERM  (T1S)
    ) u_hold_timer (
        .CLK  (CLK),
        .RSTn (RSTn),
        .clr  (press_set),
        .en   (state == WAIT_REL),
        .done (hold_done)
    );

    // Pulse on the rising edge of hold_done; the counter then saturates.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            hold_done_d <= 1'b0;
            Key_Long    <= 1'b0;
        end else begin
            hold_done_d <= hold_done;
            Key_Long    <= hold_done && !hold_done_d;
        end
    end
`else
    logic unused_t1s;
    assign unused_t1s = ^T1S;
    assign Key_Long   = 1'b0;
`endif

    assign dbg_state = state;

endmodule

// File: tb/tb_key_debounce_ctrl.sv
`timescale 1ns/1ps
module tb_key_debounce_ctrl;
    import key_pkg::*;

    localparam int DLY  = 9;
    localparam int HOLD = 99;

    // ---------------- clock / reset / DUT ----------------
    logic       CLK     = 1'b0;
    logic       RSTn    = 1'b0;
    logic       Pin_In  = 1'b1;
    logic       H2L_Sig = 1'b0;
    logic       L2H_Sig = 1'b0;
    logic       Key_Press, Key_Release, Key_Level, Key_Long;
    key_state_t dbg_state;

    always #10 CLK = ~CLK;

    key_debounce_ctrl #(
        .T10MS (20'd9),
        .T1S   (26'd99)
    ) dut (
        .CLK         (CLK),
        .RSTn        (RSTn),
        .Pin_In      (Pin_In),
        .H2L_Sig     (H2L_Sig),
        .L2H_Sig     (L2H_Sig),
        .Key_Press   (Key_Press),
        .Key_Release (Key_Release),
        .Key_Level   (Key_Level),
        .Key_Long    (Key_Long),
        .dbg_state   (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // ---------------- reference model ----------------
    // Phases: 0 released, 1 press window, 2 held, 3 release window.
    // A window lasts DLY+1 cycles; the decision uses the level seen on its last cycle.
    int m_phase, m_win, m_held;
    bit m_fired;
    bit exp_press, exp_rel, exp_long, exp_level;

    task automatic model_reset();
        m_phase   = 0;
        m_win     = 0;
        m_held    = 0;
        m_fired   = 1'b0;
        exp_press = 1'b0;
        exp_rel   = 1'b0;
        exp_long  = 1'b0;
        exp_level = 1'b1;
    endtask

    task automatic model_edge(input bit h, input bit l, input bit pin);
        exp_press = 1'b0;
        exp_rel   = 1'b0;
        exp_long  = 1'b0;
`ifdef KEY_LONG_PRESS_EN
        // One pulse once the held time reaches HOLD cycles; hold time only
        // accumulates while held, and is kept across release bounces.
        if (m_held == HOLD && !m_fired) begin
            exp_long = 1'b1;
            m_fired  = 1'b1;
        end
        if (m_phase == 2 && m_held < HOLD) m_held++;
`endif
        case (m_phase)
            0: if (h) begin m_phase = 1; m_win = 0; end
            1: if (m_win == DLY) begin
                   if (!pin) begin
                       m_phase = 2; exp_press = 1'b1; exp_level = 1'b0;
                       m_held = 0; m_fired = 1'b0;
                   end else m_phase = 0;
               end else m_win++;
            2: if (l) begin m_phase = 3; m_win = 0; end
            default: if (m_win == DLY) begin
                   if (pin) begin
                       m_phase = 0; exp_rel = 1'b1; exp_level = 1'b1;
                   end else m_phase = 2;
               end else m_win++;
        endcase
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge CLK);
        model_edge(H2L_Sig, L2H_Sig, Pin_In);
        #1;
    endtask

    task automatic do_reset();
        RSTn    = 1'b0;
        Pin_In  = 1'b1;
        H2L_Sig = 1'b0;
        L2H_Sig = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        RSTn = 1'b1;
        model_reset();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++; if (Key_Press !== 1'b0)   begin errors++; $display("FAIL reset_press got=%b exp=0", Key_Press); end
        checks++; if (Key_Release !== 1'b0) begin errors++; $display("FAIL reset_release got=%b exp=0", Key_Release); end
        checks++; if (Key_Long !== 1'b0)    begin errors++; $display("FAIL reset_long got=%b exp=0", Key_Long); end
        checks++; if (Key_Level !== 1'b1)   begin errors++; $display("FAIL reset_level got=%b exp=1", Key_Level); end
        checks++; if (dbg_state !== IDLE)   begin errors++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, IDLE); end
    endtask

    // Press at cycle 0 confirmed at 11; release edge at 50 confirmed at 61.
    task automatic test_press_release();
        do_reset();
        for (int c = 0; c <= 66; c++) begin
            H2L_Sig = (c == 0);
            L2H_Sig = (c == 50);
            Pin_In  = (c >= 50);
            checks++;
            if (Key_Press !== (c == 11)) begin
                errors++; $display("FAIL press_pulse c=%0d got=%b exp=%b", c, Key_Press, c == 11);
            end
            checks++;
            if (Key_Release !== (c == 61)) begin
                errors++; $display("FAIL release_pulse c=%0d got=%b exp=%b", c, Key_Release, c == 61);
            end
            checks++;
            if (Key_Level !== !(c >= 11 && c < 61)) begin
                errors++; $display("FAIL press_level c=%0d got=%b exp=%b", c, Key_Level, !(c >= 11 && c < 61));
            end
            step();
        end
        H2L_Sig = 1'b0; L2H_Sig = 1'b0;
    endtask

    task automatic test_glitch();
        do_reset();
        for (int c = 0; c <= 20; c++) begin
            H2L_Sig = (c == 0);
            Pin_In  = (c >= 3);
            checks++;
            if (Key_Press !== 1'b0 || Key_Level !== 1'b1) begin
                errors++; $display("FAIL glitch_out c=%0d press=%b level=%b exp press=0 level=1", c, Key_Press, Key_Level);
            end
            if (c == 11) begin
                checks++;
                if (dbg_state !== IDLE) begin
                    errors++; $display("FAIL glitch_state got=%0d exp=%0d", dbg_state, IDLE);
                end
            end
            step();
        end
        H2L_Sig = 1'b0;
    endtask

    task automatic test_bouncy_press();
        int n_press;
        n_press = 0;
        do_reset();
        for (int c = 0; c <= 30; c++) begin
            H2L_Sig = (c == 0) || (c == 2) || (c == 6);
            L2H_Sig = (c == 4);
            Pin_In  = (c >= 2 && c < 9);
            if (Key_Press === 1'b1) n_press++;
            checks++;
            if (Key_Press !== (c == 11)) begin
                errors++; $display("FAIL bouncy_press c=%0d got=%b exp=%b", c, Key_Press, c == 11);
            end
            step();
        end
        checks++;
        if (n_press != 1) begin
            errors++; $display("FAIL bouncy_count got=%0d exp=1", n_press);
        end
        H2L_Sig = 1'b0; L2H_Sig = 1'b0;
    endtask

    // Confirm at cycle 11; with the feature on the pulse lands HOLD+1 cycles later.
    task automatic test_long_press();
        int  n_long;
        bit  want;
        n_long = 0;
        do_reset();
        for (int c = 0; c <= 200; c++) begin
            H2L_Sig = (c == 0);
            L2H_Sig = (c == 170);
            Pin_In  = (c >= 170);
`ifdef KEY_LONG_PRESS_EN
            want = (c == 11 + HOLD + 1);
`else
            want = 1'b0;
`endif
            if (Key_Long === 1'b1) n_long++;
            checks++;
            if (Key_Long !== want) begin
                errors++; $display("FAIL long_pulse c=%0d got=%b exp=%b", c, Key_Long, want);
            end
            checks++;
            if ((Key_Long & (Key_Press | Key_Release)) !== 1'b0) begin
                errors++; $display("FAIL long_overlap c=%0d long=%b press=%b rel=%b", c, Key_Long, Key_Press, Key_Release);
            end
            step();
        end
        checks++;
`ifdef KEY_LONG_PRESS_EN
        if (n_long != 1) begin errors++; $display("FAIL long_count got=%0d exp=1", n_long); end
`else
        if (n_long != 0) begin errors++; $display("FAIL long_count got=%0d exp=0", n_long); end
`endif
        H2L_Sig = 1'b0; L2H_Sig = 1'b0;
    endtask

    task automatic test_reset_mid_delay();
        do_reset();
        for (int c = 0; c < 5; c++) begin
            H2L_Sig = (c == 0);
            Pin_In  = 1'b0;
            step();
        end
        RSTn = 1'b0;
        #1;
        checks++;
        if (Key_Press !== 1'b0 || Key_Release !== 1'b0 || Key_Long !== 1'b0 ||
            Key_Level !== 1'b1 || dbg_state !== IDLE) begin
            errors++;
            $display("FAIL mid_reset_out press=%b rel=%b long=%b level=%b state=%0d exp 0 0 0 1 %0d",
                     Key_Press, Key_Release, Key_Long, Key_Level, dbg_state, IDLE);
        end
        repeat (2) @(posedge CLK);
        #1;
        RSTn = 1'b1;
        model_reset();
        for (int c = 0; c < 25; c++) begin
            checks++;
            if (Key_Press !== 1'b0 || Key_Level !== 1'b1) begin
                errors++; $display("FAIL mid_reset_after c=%0d press=%b level=%b exp press=0 level=1", c, Key_Press, Key_Level);
            end
            step();
        end
        Pin_In = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 5000; c++) begin
            H2L_Sig = ($urandom_range(0, 15) == 0);
            L2H_Sig = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 39) == 0) Pin_In = ~Pin_In;
            checks++;
            if (Key_Press !== exp_press || Key_Release !== exp_rel ||
                Key_Long !== exp_long || Key_Level !== exp_level) begin
                errors++;
                $display("FAIL random c=%0d got p/r/l/lv=%b%b%b%b exp=%b%b%b%b",
                         c, Key_Press, Key_Release, Key_Long, Key_Level,
                         exp_press, exp_rel, exp_long, exp_level);
            end
            step();
        end
        H2L_Sig = 1'b0; L2H_Sig = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        model_reset();
        test_reset();
        test_press_release();
        test_glitch();
        test_bouncy_press();
        test_long_press();
        test_reset_mid_delay();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
